// File: rtl/rx_descramble_gate.sv
// rx_descramble_gate
//
// Per-lane descrambler bypass controller for the PCIe MAC receive path.
// It sits between the PIPE RX data stage and the per-lane descramblers. It
// registers each lane's data and attaches a bypass flag that tells the
// descrambler to pass the data through untouched. Bypass is raised while
// descrambling is not yet enabled, for the whole length of an ordered set
// (8b/10b COM-led, or a 128b/130b ordered-set block), and for zero-filled
// lane data seen while the LTSSM sits in the arming substate.
//
// Ports
//   clk               clock
//   reset             asynchronous, active-low reset
//   GEN               current generation, GEN<3 selects 8b/10b handling
//   substate          LTSSM substate code
//   disableScrambler  1 = descrambling forbidden
//   RxData/RxDataK    lane data and per-byte K flags (lane i at [i*DATAW +: DATAW])
//   RxValid           per-lane valid (0 = stall)
//   RxStartBlock      first cycle of a 128b/130b block
//   RxSyncHeader      2-bit sync header per lane, valid with RxStartBlock
//   Gate*             registered copies of the Rx* lane inputs
//   bypass            per-lane descrambler bypass, aligned with Gate*
//   enabled           global FSM is in ENABLED
//   osStart           one-cycle pulse marking an ordered-set start, aligned with Gate*
//
// Global FSM
//   state        | meaning
//   ST_DISABLED  | descrambling off, waiting for the arming substate
//   ST_ARMING    | arming substate seen, counting down ENABLE_DELAY cycles
//   ST_ENABLED   | descrambling on, until a force-off condition

module rx_descramble_gate #(
  parameter int LANES          = 16,
  parameter int DATAW          = 32,
  parameter int ENABLE_DELAY   = 2,
  parameter int ARM_SUBSTATE   = 9,
  parameter int RESET_SUBSTATE = 1,
  parameter int OS8B_CYCLES    = 4,
  parameter int OS128B_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               GEN,
  input  logic [4:0]               substate,
  input  logic                     disableScrambler,
  input  logic [LANES*DATAW-1:0]   RxData,
  input  logic [LANES*DATAW/8-1:0] RxDataK,
  input  logic [LANES-1:0]         RxValid,
  input  logic [LANES-1:0]         RxStartBlock,
  input  logic [2*LANES-1:0]       RxSyncHeader,
  output logic [LANES*DATAW-1:0]   GateData,
  output logic [LANES*DATAW/8-1:0] GateDataK,
  output logic [LANES-1:0]         GateValid,
  output logic [2*LANES-1:0]       GateSyncHeader,
  output logic [LANES-1:0]         bypass,
  output logic                     enabled,
  output logic [LANES-1:0]         osStart
);

  localparam int KW     = DATAW / 8;
  localparam int OS_MAX = (OS8B_CYCLES > OS128B_CYCLES) ? OS8B_CYCLES : OS128B_CYCLES;
  localparam int OSW    = $clog2(OS_MAX) + 1;
  localparam int ARMW   = $clog2(ENABLE_DELAY) + 1;

  localparam logic [OSW-1:0]  OS8B_LOAD   = OSW'(OS8B_CYCLES - 1);
  localparam logic [OSW-1:0]  OS128B_LOAD = OSW'(OS128B_CYCLES - 1);
  localparam logic [OSW-1:0]  OS_ONE      = OSW'(1);
  localparam logic [ARMW-1:0] ARM_LOAD    = ARMW'(ENABLE_DELAY - 1);
  localparam logic [ARMW-1:0] ARM_ONE     = ARMW'(1);
  localparam logic [4:0]      ARM_SS      = 5'(ARM_SUBSTATE);
  localparam logic [4:0]      RST_SS      = 5'(RESET_SUBSTATE);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMING   = 2'd1;
  localparam logic [1:0] ST_ENABLED  = 2'd2;

  // Global enable FSM
  logic [1:0]      state_q, state_d;
  logic [ARMW-1:0] arm_cnt_q, arm_cnt_d;
  logic            force_off;

  // Generation tracking; gen_seen_q keeps the first cycle after reset from
  // being mistaken for a generation change.
  logic [2:0] gen_q, gen_d;
  logic       gen_seen_q, gen_seen_d;
  logic       gen_8b;
  logic       gen_chg;

  // Per-lane ordered-set tracking
  logic [LANES-1:0][OSW-1:0] os_cnt_q, os_cnt_d;
  logic [LANES-1:0]          hit;
  logic [LANES-1:0]          zero;

  // Output registers
  logic [LANES*DATAW-1:0]   gate_data_q, gate_data_d;
  logic [LANES*DATAW/8-1:0] gate_data_k_q, gate_data_k_d;
  logic [LANES-1:0]         gate_valid_q, gate_valid_d;
  logic [2*LANES-1:0]       gate_sync_q, gate_sync_d;
  logic [LANES-1:0]         bypass_q, bypass_d;
  logic [LANES-1:0]         os_start_q, os_start_d;
  logic                     enabled_q, enabled_d;

  // ARMING is a down-counter loaded with ENABLE_DELAY-1 on entry and left on
  // terminal count, so the FSM spends exactly ENABLE_DELAY cycles in ARMING.
  // Leaving the arming substate does not abort the count; only force-off does.
  always_comb begin
    force_off = (substate == RST_SS) || disableScrambler;
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (force_off) begin
      state_d   = ST_DISABLED;
      arm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          if (substate == ARM_SS) begin
            state_d   = ST_ARMING;
            arm_cnt_d = ARM_LOAD;
          end
        end
        ST_ARMING: begin
          if (arm_cnt_q == '0) begin
            state_d = ST_ENABLED;
          end else begin
            arm_cnt_d = arm_cnt_q - ARM_ONE;
          end
        end
        ST_ENABLED: begin
          state_d = ST_ENABLED;
        end
        default: begin
          state_d   = ST_DISABLED;
          arm_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    gen_8b     = (GEN < 3'd3);
    gen_chg    = gen_seen_q && (GEN != gen_q);
    gen_d      = GEN;
    gen_seen_d = 1'b1;
  end

  // Hit detection, zero-fill detection and ordered-set countdown per lane.
  // A hit reloads the countdown even in the middle of a previous ordered set;
  // a stalled lane (RxValid low) holds its count. A generation change wipes
  // all counts because the framing they were tracking no longer applies.
  always_comb begin
    hit      = '0;
    zero     = '0;
    os_cnt_d = os_cnt_q;
    bypass_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (gen_8b) begin
        hit[i] = RxValid[i] && (RxData[i*DATAW +: 8] == 8'hBC) && RxDataK[i*KW];
      end else begin
        hit[i] = RxValid[i] && RxStartBlock[i] && (RxSyncHeader[2*i +: 2] == 2'b01);
      end
      zero[i] = (substate == ARM_SS) && RxValid[i] && (RxData[i*DATAW +: DATAW] == '0);

      if (gen_chg) begin
        os_cnt_d[i] = '0;
      end else if (hit[i]) begin
        os_cnt_d[i] = gen_8b ? OS8B_LOAD : OS128B_LOAD;
      end else if (RxValid[i] && (os_cnt_q[i] != '0)) begin
        os_cnt_d[i] = os_cnt_q[i] - OS_ONE;
      end

      bypass_d[i] = (state_q != ST_ENABLED) || hit[i] || (os_cnt_q[i] != '0) || zero[i];
    end
  end

  always_comb begin
    gate_data_d   = RxData;
    gate_data_k_d = RxDataK;
    gate_valid_d  = RxValid;
    gate_sync_d   = RxSyncHeader;
    os_start_d    = hit;
    enabled_d     = (state_d == ST_ENABLED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_DISABLED;
      arm_cnt_q     <= '0;
      gen_q         <= '0;
      gen_seen_q    <= 1'b0;
      os_cnt_q      <= '0;
      gate_data_q   <= '0;
      gate_data_k_q <= '0;
      gate_valid_q  <= '0;
      gate_sync_q   <= '0;
      bypass_q      <= '1;
      os_start_q    <= '0;
      enabled_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      gen_q         <= gen_d;
      gen_seen_q    <= gen_seen_d;
      os_cnt_q      <= os_cnt_d;
      gate_data_q   <= gate_data_d;
      gate_data_k_q <= gate_data_k_d;
      gate_valid_q  <= gate_valid_d;
      gate_sync_q   <= gate_sync_d;
      bypass_q      <= bypass_d;
      os_start_q    <= os_start_d;
      enabled_q     <= enabled_d;
    end
  end

  assign GateData       = gate_data_q;
  assign GateDataK      = gate_data_k_q;
  assign GateValid      = gate_valid_q;
  assign GateSyncHeader = gate_sync_q;
  assign bypass         = bypass_q;
  assign osStart        = os_start_q;
  assign enabled        = enabled_q;

endmodule

// File: tb/tb_rx_descramble_gate.sv
module tb_rx_descramble_gate;

  localparam int LANES = 16;
  localparam int DATAW = 32;
  localparam int KW    = DATAW / 8;
  localparam int ED    = 2;
  localparam int ARM   = 9;
  localparam int RST   = 1;
  localparam int OS8   = 4;
  localparam int OS128 = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [2:0]               GEN;
  logic [4:0]               substate;
  logic                     disableScrambler;
  logic [LANES*DATAW-1:0]   RxData;
  logic [LANES*KW-1:0]      RxDataK;
  logic [LANES-1:0]         RxValid;
  logic [LANES-1:0]         RxStartBlock;
  logic [2*LANES-1:0]       RxSyncHeader;
  logic [LANES*DATAW-1:0]   GateData;
  logic [LANES*KW-1:0]      GateDataK;
  logic [LANES-1:0]         GateValid;
  logic [2*LANES-1:0]       GateSyncHeader;
  logic [LANES-1:0]         bypass;
  logic                     enabled;
  logic [LANES-1:0]         osStart;

  rx_descramble_gate #(
    .LANES(LANES), .DATAW(DATAW), .ENABLE_DELAY(ED), .ARM_SUBSTATE(ARM),
    .RESET_SUBSTATE(RST), .OS8B_CYCLES(OS8), .OS128B_CYCLES(OS128)
  ) dut (
    .clk(clk), .reset(reset), .GEN(GEN), .substate(substate),
    .disableScrambler(disableScrambler), .RxData(RxData), .RxDataK(RxDataK),
    .RxValid(RxValid), .RxStartBlock(RxStartBlock), .RxSyncHeader(RxSyncHeader),
    .GateData(GateData), .GateDataK(GateDataK), .GateValid(GateValid),
    .GateSyncHeader(GateSyncHeader), .bypass(bypass), .enabled(enabled),
    .osStart(osStart)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = off, 1 = arming, 2 = on. Arming is tracked by
  // the cycle number it began in; ordered sets by remaining covered cycles.
  int m_mode;
  int m_cyc;
  int m_arm_first;
  int m_gen_prev;
  int m_rem [LANES];

  logic [LANES*DATAW-1:0] e_data;
  logic [LANES*KW-1:0]    e_k;
  logic [LANES-1:0]       e_valid;
  logic [2*LANES-1:0]     e_sync;
  logic [LANES-1:0]       e_bypass;
  logic [LANES-1:0]       e_os;
  logic                   e_en;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_cyc       = 0;
    m_arm_first = 0;
    m_gen_prev  = -1;
    for (int i = 0; i < LANES; i++) m_rem[i] = 0;
  endtask

  task automatic compare_outputs();
    chk("gate_data",  GateData,       e_data);
    chk("gate_k",     GateDataK,      e_k);
    chk("gate_valid", GateValid,      e_valid);
    chk("gate_sync",  GateSyncHeader, e_sync);
    chk("bypass",     bypass,         e_bypass);
    chk("os_start",   osStart,        e_os);
    chk("enabled",    enabled,        e_en);
  endtask

  // One clock: predict outputs from current inputs and model state, take the
  // edge, then compare.
  task automatic step();
    logic [LANES-1:0] hit;
    logic [LANES-1:0] zro;
    int               nmode;
    bit               off;
    bit               gchg;
    bit               is8b;
    is8b = (GEN < 3);
    off  = (substate == RST) || disableScrambler;
    for (int i = 0; i < LANES; i++) begin
      if (is8b)
        hit[i] = RxValid[i] && (RxData[i*DATAW +: 8] == 8'hBC) && RxDataK[i*KW];
      else
        hit[i] = RxValid[i] && RxStartBlock[i] && (RxSyncHeader[2*i +: 2] == 2'b01);
      zro[i] = (substate == ARM) && RxValid[i] && (RxData[i*DATAW +: DATAW] == '0);
    end
    nmode = m_mode;
    if (off) nmode = 0;
    else if (m_mode == 0 && substate == ARM) begin
      nmode       = 1;
      m_arm_first = m_cyc + 1;
    end else if (m_mode == 1 && (m_cyc - m_arm_first + 1) >= ED) nmode = 2;

    for (int i = 0; i < LANES; i++)
      e_bypass[i] = (m_mode != 2) || hit[i] || (m_rem[i] > 0) || zro[i];
    e_os    = hit;
    e_en    = (nmode == 2);
    e_data  = RxData;
    e_k     = RxDataK;
    e_valid = RxValid;
    e_sync  = RxSyncHeader;

    gchg = (m_gen_prev >= 0) && (m_gen_prev != int'(GEN));
    for (int i = 0; i < LANES; i++) begin
      if (gchg) m_rem[i] = 0;
      else if (hit[i]) m_rem[i] = (is8b ? OS8 : OS128) - 1;
      else if (RxValid[i] && m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
    end
    m_gen_prev = int'(GEN);
    m_mode     = nmode;
    m_cyc++;

    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic set_idle();
    for (int i = 0; i < LANES; i++) begin
      RxData[i*DATAW +: DATAW] = 32'h5A00_0000 | (i + 1);
      RxSyncHeader[2*i +: 2]   = 2'b10;
    end
    RxDataK      = '0;
    RxValid      = '1;
    RxStartBlock = '0;
  endtask

  task automatic set_com(input int lane);
    RxData[lane*DATAW +: 8] = 8'hBC;
    RxDataK[lane*KW]        = 1'b1;
  endtask

  initial begin
    reset            = 1'b0;
    GEN              = 3'd1;
    substate         = 5'd0;
    disableScrambler = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bypass",  bypass,   16'hFFFF);
    chk("rst_enabled", enabled,  1'b0);
    chk("rst_os",      osStart,  16'h0000);
    chk("rst_data",    GateData, '0);
    reset = 1'b1;
    repeat (2) step();

    // Enable sequence: arming sampled in cycle 0, ARMING in cycles 1..2
    disableScrambler = 1'b0;
    substate         = 5'd9;
    step(); chk("en_c0", enabled, 1'b0);
    step(); chk("en_c1", enabled, 1'b0);
    step(); chk("en_c2", enabled, 1'b1); chk("byp_c2", bypass, 16'hFFFF);
    step(); chk("byp_c3", bypass, 16'h0000);
    repeat (6) step();
    disableScrambler = 1'b1;
    step(); chk("dis_en", enabled, 1'b0);
    step(); chk("dis_byp", bypass, 16'hFFFF);
    substate = 5'd5;
    step();
    disableScrambler = 1'b0;
    step();

    // Reset substate aborts ARMING; re-arming restarts the delay
    substate = 5'd9; step();
    substate = 5'd1; step(); chk("abort_en", enabled, 1'b0);
    substate = 5'd5; step(); step(); chk("abort_stay", enabled, 1'b0);
    substate = 5'd9; step(); chk("rearm_0", enabled, 1'b0);
    substate = 5'd5; step(); chk("rearm_1", enabled, 1'b0);
    step(); chk("rearm_2", enabled, 1'b1);

    // GEN1 COM on lane 3
    for (int k = 0; k < 6; k++) begin
      set_idle();
      if (k == 0) set_com(3);
      step();
      chk("com_byp3", bypass[3], (k < 4));
      chk("com_os3",  osStart[3], (k == 0));
      chk("com_oth",  bypass & ~16'h0008, 16'h0000);
    end

    // Back-to-back COM: second hit two cycles after the first
    for (int k = 0; k < 8; k++) begin
      set_idle();
      if (k == 0 || k == 2) set_com(3);
      step();
      chk("b2b_byp3", bypass[3], (k < 6));
      chk("b2b_os3",  osStart[3], (k == 0 || k == 2));
    end

    // GEN3 ordered-set block on lane 0 with a 2-cycle stall
    GEN = 3'd3;
    set_idle();
    repeat (2) step();
    for (int k = 0; k < 8; k++) begin
      set_idle();
      if (k == 0) begin
        RxStartBlock[0]    = 1'b1;
        RxSyncHeader[1:0]  = 2'b01;
      end
      if (k == 2 || k == 3) RxValid[0] = 1'b0;
      step();
      chk("osb_byp0", bypass[0], (k <= 5));
    end
    // Same stimulus as a data block
    for (int k = 0; k < 8; k++) begin
      set_idle();
      if (k == 0) RxStartBlock[0] = 1'b1;
      if (k == 2 || k == 3) RxValid[0] = 1'b0;
      step();
      chk("dblk_byp0", bypass[0], 1'b0);
      chk("dblk_os0",  osStart[0], 1'b0);
    end

    // GEN change mid-block clears the ordered-set count
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k == 0) begin
        RxStartBlock[0]   = 1'b1;
        RxSyncHeader[1:0] = 2'b01;
      end
      if (k == 2) GEN = 3'd1;
      step();
      chk("genchg_byp0", bypass[0], (k <= 2));
    end

    // Zero-fill on lane 5 at the arming substate while enabled
    substate = 5'd9;
    for (int k = 0; k < 4; k++) begin
      set_idle();
      if (k == 1 || k == 2) RxData[5*DATAW +: DATAW] = '0;
      step();
      chk("zero_byp", bypass, (k == 1 || k == 2) ? 16'h0020 : 16'h0000);
    end
    substate = 5'd5;

    // Asynchronous reset in the middle of an ordered set on lane 2
    set_idle(); set_com(2); step();
    set_idle(); step();
    #2 reset = 1'b0;
    #1;
    chk("arst_byp", bypass,   16'hFFFF);
    chk("arst_en",  enabled,  1'b0);
    chk("arst_os",  osStart,  16'h0000);
    chk("arst_dat", GateData, '0);
    @(posedge clk);
    #1;
    chk("arst_hold", bypass, 16'hFFFF);
    reset = 1'b1;
    model_reset();
    substate = 5'd9;
    repeat (3) step();
    chk("post_en", enabled, 1'b1);
    substate = 5'd5;
    step();
    chk("post_byp", bypass, 16'h0000);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
